// File: rtl/letter_fall_scheduler.sv
// Purpose : game sequencer owning three falling letter slots (spawn, fall, hit, miss, score, lives).
// Latency : all outputs registered; a guess strobe or fall tick is reflected one cycle later.
// Backpres: none; guess_valid is a single-cycle strobe, never stalled, ignored outside PLAY.
//
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   start                 one-cycle pulse, begins or restarts a game
//   guess, guess_valid    player-entered value and its qualifying strobe
//   letter1..3, ypos1..3  slot values and rows to the renderer (0 when slot empty)
//   slot_active           bit i-1 set when slot i is occupied
//   score, lives          saturating hit count, remaining lives
//   playing, game_over    state flags (PLAY, OVER)
//
// Optional feature: define SCHED_SPEEDUP_EN to halve the fall period after every 8th hit
// (period FALL_DIV>>k, k saturating at 3, cleared on start).
module letter_fall_scheduler #(
    parameter int FALL_DIV    = 25_000_000,
    parameter int SPAWN_DIV   = 75_000_000,
    parameter int MAX_Y       = 23,
    parameter int START_LIVES = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] guess,
    input  logic       guess_valid,
    output logic [7:0] letter1,
    output logic [7:0] letter2,
    output logic [7:0] letter3,
    output logic [4:0] ypos1,
    output logic [4:0] ypos2,
    output logic [4:0] ypos3,
    output logic [2:0] slot_active,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       playing,
    output logic       game_over
);

    localparam int FW = $clog2(FALL_DIV + 1);
    localparam int SW = $clog2(SPAWN_DIV + 1);

    // Encoding chosen so playing/game_over are plain register bits.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PLAY = 2'b01;
    localparam logic [1:0] S_OVER = 2'b10;

    localparam logic [4:0]    YMAX       = 5'(MAX_Y);
    localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_DIV - 1);
    localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);

    logic [1:0]    state_q;
    logic [7:0]    lfsr_q;
    logic [FW-1:0] fall_cnt_q;
    logic [SW-1:0] spawn_cnt_q;
    logic [7:0]    letter_q [3];
    logic [4:0]    ypos_q   [3];
    logic [2:0]    active_q;
    logic [7:0]    score_q;
    logic [1:0]    lives_q;

`ifdef SCHED_SPEEDUP_EN
    logic [1:0]    speed_k_q;
    logic [2:0]    hit_cnt_q;
    int            fall_div_eff;
`endif

    logic          run;
    logic          tick;
    logic          spawn_tc;
    logic [FW-1:0] fall_last;
    logic [2:0]    hit_oh;
    logic          hit_found;
    logic [4:0]    best_y;
    logic [2:0]    free_oh;
    logic [2:0]    miss;
    logic [1:0]    miss_cnt;
    logic [1:0]    lives_next;
    logic          lfsr_fb;

    // x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    // The cycle in which lives is already 0 is spent leaving PLAY: no slot activity.
    assign run = (state_q == S_PLAY) && (lives_q != 2'd0) && !start;

    always_comb begin
`ifdef SCHED_SPEEDUP_EN
        fall_div_eff = FALL_DIV >> speed_k_q;
        fall_last    = (fall_div_eff > 1) ? FW'(fall_div_eff - 1) : '0;
`else
        fall_last    = FW'(FALL_DIV - 1);
`endif
    end

    assign tick     = run && (fall_cnt_q == fall_last);
    assign spawn_tc = run && (spawn_cnt_q == SPAWN_LAST);

    // Hit select: deepest matching slot wins; strict '>' keeps the lowest index on ties.
    always_comb begin
        hit_oh    = '0;
        hit_found = 1'b0;
        best_y    = '0;
        for (int i = 0; i < 3; i++) begin
            if (run && guess_valid && active_q[i] && (letter_q[i] == guess) &&
                (!hit_found || (ypos_q[i] > best_y))) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                hit_found = 1'b1;
                best_y    = ypos_q[i];
            end
        end
    end

    // Free slot is judged on the pre-update occupancy, so a slot freed this cycle
    // is only reusable by a later spawn.
    always_comb begin
        free_oh = '0;
        for (int i = 0; i < 3; i++) begin
            if (!active_q[i] && (free_oh == 3'b000)) begin
                free_oh[i] = 1'b1;
            end
        end
    end

    // A hit on the miss tick pre-empts the miss.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            miss[i] = tick && active_q[i] && (ypos_q[i] == YMAX) && !hit_oh[i];
        end
        miss_cnt   = {1'b0, miss[0]} + {1'b0, miss[1]} + {1'b0, miss[2]};
        lives_next = (lives_q > miss_cnt) ? (lives_q - miss_cnt) : 2'd0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= 8'hA5;
            fall_cnt_q  <= '0;
            spawn_cnt_q <= '0;
            active_q    <= '0;
            score_q     <= '0;
            lives_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                letter_q[i] <= '0;
                ypos_q[i]   <= '0;
            end
`ifdef SCHED_SPEEDUP_EN
            speed_k_q   <= '0;
            hit_cnt_q   <= '0;
`endif
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_fb};

            if (start) begin
                state_q     <= S_PLAY;
                fall_cnt_q  <= '0;
                spawn_cnt_q <= '0;
                active_q    <= '0;
                score_q     <= '0;
                lives_q     <= LIVES_INIT;
                for (int i = 0; i < 3; i++) begin
                    letter_q[i] <= '0;
                    ypos_q[i]   <= '0;
                end
`ifdef SCHED_SPEEDUP_EN
                speed_k_q   <= '0;
                hit_cnt_q   <= '0;
`endif
            end else if (state_q == S_PLAY) begin
                if (lives_q == 2'd0) begin
                    state_q     <= S_OVER;
                    fall_cnt_q  <= '0;
                    spawn_cnt_q <= '0;
                end else begin
                    fall_cnt_q  <= tick ? '0 : fall_cnt_q + 1'b1;
                    spawn_cnt_q <= spawn_tc ? '0 : spawn_cnt_q + 1'b1;

                    // Per-slot priority: hit, then miss, then fall, then spawn into a free slot.
                    for (int i = 0; i < 3; i++) begin
                        if (hit_oh[i] || miss[i]) begin
                            active_q[i] <= 1'b0;
                            letter_q[i] <= '0;
                            ypos_q[i]   <= '0;
                        end else if (tick && active_q[i]) begin
                            ypos_q[i]   <= ypos_q[i] + 5'd1;
                        end else if (spawn_tc && free_oh[i]) begin
                            active_q[i] <= 1'b1;
                            letter_q[i] <= lfsr_q;
                            ypos_q[i]   <= '0;
                        end
                    end

                    if (hit_found && (score_q != 8'hFF)) begin
                        score_q <= score_q + 8'd1;
                    end
                    lives_q <= lives_next;

`ifdef SCHED_SPEEDUP_EN
                    if (hit_found) begin
                        hit_cnt_q <= hit_cnt_q + 3'd1;
                        if ((hit_cnt_q == 3'd7) && (speed_k_q != 2'd3)) begin
                            speed_k_q  <= speed_k_q + 2'd1;
                            fall_cnt_q <= '0;
                        end
                    end
`endif
                end
            end
        end
    end

    assign letter1     = letter_q[0];
    assign letter2     = letter_q[1];
    assign letter3     = letter_q[2];
    assign ypos1       = ypos_q[0];
    assign ypos2       = ypos_q[1];
    assign ypos3       = ypos_q[2];
    assign slot_active = active_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign playing     = state_q[0];
    assign game_over   = state_q[1];

endmodule

// File: tb/tb_letter_fall_scheduler.sv
// Purpose : self-checking bench for letter_fall_scheduler against a cycle-level game model.
// Latency : outputs sampled 1 time unit after each rising clock edge.
// Backpres: none; the bench drives start/guess strobes freely.
module tb_letter_fall_scheduler;

    localparam int FALL_DIV    = 16;
    localparam int SPAWN_DIV   = 85;   // 3*85 = 255: every third spawn repeats an LFSR value
    localparam int MAX_Y       = 23;
    localparam int START_LIVES = 3;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [7:0] guess;
    logic       guess_valid;
    logic [7:0] letter1, letter2, letter3;
    logic [4:0] ypos1, ypos2, ypos3;
    logic [2:0] slot_active;
    logic [7:0] score;
    logic [1:0] lives;
    logic       playing;
    logic       game_over;

    letter_fall_scheduler #(
        .FALL_DIV    (FALL_DIV),
        .SPAWN_DIV   (SPAWN_DIV),
        .MAX_Y       (MAX_Y),
        .START_LIVES (START_LIVES)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .guess       (guess),
        .guess_valid (guess_valid),
        .letter1     (letter1),
        .letter2     (letter2),
        .letter3     (letter3),
        .ypos1       (ypos1),
        .ypos2       (ypos2),
        .ypos3       (ypos3),
        .slot_active (slot_active),
        .score       (score),
        .lives       (lives),
        .playing     (playing),
        .game_over   (game_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- game model ----------------
    int         m_mode;            // 0 idle, 1 play, 2 over
    logic [7:0] m_lfsr;
    logic [7:0] m_let [3];
    int         m_y   [3];
    bit         m_act [3];
    int         m_score, m_lives;
    int         m_cyc;             // play cycles since start (spawn phase)
    int         m_fcyc;            // play cycles since fall period last restarted
    int         m_k, m_hits;

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    task automatic clear_slot(input int i);
        m_act[i] = 0; m_let[i] = 8'h00; m_y[i] = 0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_lfsr = 8'hA5; m_score = 0; m_lives = 0;
        m_cyc = 0; m_fcyc = 0; m_k = 0; m_hits = 0;
        for (int i = 0; i < 3; i++) clear_slot(i);
    endtask

    task automatic model_next();
        logic [7:0] cur;
        int h, f, misses, per;
        bit tk, sp;
        cur    = m_lfsr;
        m_lfsr = lfsr_adv(m_lfsr);
        if (start) begin
            m_mode = 1; m_score = 0; m_lives = START_LIVES;
            m_cyc = 0; m_fcyc = 0; m_k = 0; m_hits = 0;
            for (int i = 0; i < 3; i++) clear_slot(i);
            return;
        end
        if (m_mode != 1) return;
        if (m_lives == 0) begin
            m_mode = 2;
            return;
        end
        per = FALL_DIV >> m_k;
        if (per < 1) per = 1;
        tk = (m_fcyc % per) == per - 1;
        sp = (m_cyc % SPAWN_DIV) == SPAWN_DIV - 1;
        m_cyc++; m_fcyc++;
        h = -1;
        if (guess_valid)
            for (int i = 0; i < 3; i++)
                if (m_act[i] && m_let[i] == guess && (h < 0 || m_y[i] > m_y[h])) h = i;
        f = -1;
        for (int i = 0; i < 3; i++) if (!m_act[i] && f < 0) f = i;
        misses = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == h) clear_slot(i);
            else if (m_act[i] && tk) begin
                if (m_y[i] == MAX_Y) begin clear_slot(i); misses++; end
                else m_y[i]++;
            end
        end
        if (sp && f >= 0) begin m_act[f] = 1; m_let[f] = cur; m_y[f] = 0; end
        if (h >= 0) begin
            if (m_score < 255) m_score++;
`ifdef SCHED_SPEEDUP_EN
            m_hits++;
            if (m_hits % 8 == 0 && m_k < 3) begin m_k++; m_fcyc = 0; end
`endif
        end
        m_lives = (m_lives > misses) ? m_lives - misses : 0;
    endtask

    task automatic compare_all();
        chk("letter1", letter1, m_let[0]);
        chk("letter2", letter2, m_let[1]);
        chk("letter3", letter3, m_let[2]);
        chk("ypos1", ypos1, m_y[0]);
        chk("ypos2", ypos2, m_y[1]);
        chk("ypos3", ypos3, m_y[2]);
        chk("slot_active", slot_active, {m_act[2], m_act[1], m_act[0]});
        chk("score", score, m_score);
        chk("lives", lives, m_lives);
        chk("playing", playing, m_mode == 1);
        chk("game_over", game_over, m_mode == 2);
    endtask

    task automatic step();
        model_next();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] g);
        guess = g; guess_valid = 1'b1;
        step();
        guess_valid = 1'b0;
    endtask

    task automatic run_to_cyc(input int target);
        for (int n = 0; n < 5000 && m_cyc < target; n++) step();
        chk("run_to_cyc", m_cyc, target);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit         start;
        int         hold;
        logic [2:0] exp_active;
        logic [1:0] exp_lives;
        logic [7:0] exp_score;
        bit         exp_playing;
        logic [4:0] exp_ypos1;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int zero_at, over_at, n;
        logic [2:0] snap_act;
        int snap_score;
        int q[$];

        vecs[0] = '{0,  5, 3'b000, 2'd0, 8'd0, 0, 5'd0};  // idle after reset
        vecs[1] = '{1,  1, 3'b000, 2'd3, 8'd0, 1, 5'd0};  // fresh game
        vecs[2] = '{0, 84, 3'b000, 2'd3, 8'd0, 1, 5'd0};  // just before first spawn
        vecs[3] = '{0,  1, 3'b001, 2'd3, 8'd0, 1, 5'd0};  // slot1 spawned at row 0
        vecs[4] = '{0, 10, 3'b001, 2'd3, 8'd0, 1, 5'd0};  // before its first tick
        vecs[5] = '{0,  1, 3'b001, 2'd3, 8'd0, 1, 5'd1};  // first fall step
        vecs[6] = '{0, 16, 3'b001, 2'd3, 8'd0, 1, 5'd2};  // one period later

        reset_n = 1'b0; start = 1'b0; guess = 8'h00; guess_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        compare_all();
        chk("reset_playing", playing, 0);
        chk("reset_lives", lives, 0);
        reset_n = 1'b1;

        foreach (vecs[v]) begin
            for (int c = 0; c < vecs[v].hold; c++) begin
                start = (c == 0) ? vecs[v].start : 1'b0;
                step();
            end
            start = 1'b0;
            chk($sformatf("vec%0d_active", v), slot_active, vecs[v].exp_active);
            chk($sformatf("vec%0d_lives", v), lives, vecs[v].exp_lives);
            chk($sformatf("vec%0d_score", v), score, vecs[v].exp_score);
            chk($sformatf("vec%0d_playing", v), playing, vecs[v].exp_playing);
            chk($sformatf("vec%0d_ypos1", v), ypos1, vecs[v].exp_ypos1);
        end

        // Hit: wrong value has no effect, right value clears slot1 and scores.
        strobe(m_let[0] ^ 8'h01);
        chk("miss_guess_score", score, 0);
        chk("miss_guess_active", slot_active, 3'b001);
        strobe(m_let[0]);
        chk("hit_active", slot_active, 3'b000);
        chk("hit_letter1", letter1, 0);
        chk("hit_score", score, 1);

        // Duplicate letters: slot2 respawns exactly 255 cycles after slot1's spawn.
        pulse_start();
        run_to_cyc(255);
        chk("dup_full", slot_active, 3'b111);
        strobe(m_let[1]);
        chk("dup_clear2", slot_active, 3'b101);
        run_to_cyc(340);
        chk("dup_refill", slot_active, 3'b111);
        chk("dup_same_letter", letter2, m_let[0]);
        strobe(m_let[0]);
        chk("dup_deepest_first", slot_active, 3'b110);
        strobe(m_let[1]);
        chk("dup_second", slot_active, 3'b100);

        // Let every letter fall through: lives run out, OVER two cycles after the tick.
        zero_at = -1;
        n = 0;
        while (game_over !== 1'b1 && n < 3000) begin
            step();
            n++;
            if (lives == 2'd0 && zero_at < 0) zero_at = n;
        end
        over_at = n;
        chk("over_reached", game_over, 1);
        chk("over_delay", over_at - zero_at, 1);
        chk("over_playing", playing, 0);

        // OVER: frame frozen, guesses ignored.
        snap_act   = {m_act[2], m_act[1], m_act[0]};
        snap_score = m_score;
        for (int i = 0; i < 20; i++) strobe(m_act[i % 3] ? m_let[i % 3] : 8'($urandom));
        chk("over_frozen_active", slot_active, snap_act);
        chk("over_frozen_score", score, snap_score);

        // Collision: hit on slot1's miss tick costs no life; spawn into full slots dropped.
        pulse_start();
        chk("restart_playing", playing, 1);
        chk("restart_lives", lives, START_LIVES);
        run_to_cyc(340);
        chk("full_active", slot_active, 3'b111);
        chk("full_no_overwrite", ypos1 == 5'd0, 0);
        for (int i = 0; i < 2000 &&
             !(m_act[0] && m_y[0] == MAX_Y && (m_fcyc % FALL_DIV) == FALL_DIV - 1); i++) step();
        chk("collide_setup", ypos1, MAX_Y);
        strobe(m_let[0]);
        chk("collide_lives", lives, START_LIVES);
        chk("collide_score", score, 1);
        chk("collide_cleared", slot_active[0], 0);

        // Randomized play against the model.
        pulse_start();
        for (int i = 0; i < 2500; i++) begin
            start       = ($urandom_range(0, 599) == 0);
            guess_valid = ($urandom_range(0, 3) == 0);
            q.delete();
            for (int s = 0; s < 3; s++) if (m_act[s]) q.push_back(s);
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                guess = m_let[q[$urandom_range(0, q.size() - 1)]];
            else
                guess = 8'($urandom);
            step();
        end
        start = 1'b0; guess_valid = 1'b0;

        // Asynchronous reset mid-game.
        pulse_start();
        repeat (100) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_active", slot_active, 0);
        chk("arst_letter1", letter1, 0);
        chk("arst_score", score, 0);
        chk("arst_lives", lives, 0);
        chk("arst_playing", playing, 0);
        chk("arst_game_over", game_over, 0);
        model_reset();
        @(posedge clock);
        #1;
        compare_all();
        reset_n = 1'b1;
        pulse_start();
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
